csr_timer: RTL and testbench
============================

# csr_timer

Constant-countdown timer behind the TCFG/TVAL/TICLR CSRs. It is the source end of the timer-interrupt path: it drives `csr_timer_intr_sync`, a level held until software clears it through TICLR, which the interrupt controller samples. The CSR file supplies write strobes and data, and reads back TCFG/TVAL from this block.

## Interface
- `CNT_W`, 32: counter width. Legal range 3..32. TCFG.InitVal occupies bits [CNT_W-1:2].

- `clk`  in  1  core clock; single clock domain.
- `resetn`  in  1  reset, asynchronous, active-low.
- `tcfg_we`  in  1  TCFG write strobe, one cycle per write.
- `tcfg_wdata`  in  32  TCFG write data:
  - bit0 = En
  - bit1 = Periodic
  - [CNT_W-1:2] = InitVal
  - other bits ignored
- `ticlr_we`  in  1  TICLR write strobe.
- `ticlr_wdata`  in  32  bit0 = CLR; other bits ignored.
- `tcfg_rdata`  out  32  {zero, InitVal, Periodic, En}.
- `tval_rdata`  out  32  current counter value, zero-extended.
- `csr_timer_intr_sync`  out  1  TI level, registered, synchronous to `clk`.

## Operation
- Registers:
  - cfg: En, Periodic, InitVal.
  - tval: CNT_W bits.
  - TI flag.
  - state.
- Load value = {InitVal, 2'b00}, CNT_W bits.
- States:
  - IDLE: not counting.
  - RUN: counting down.
  - DONE: one-shot expired, holds.
- TCFG write, highest priority:
  - cfg ← wdata fields.
  - tval ← load value.
  - state ← RUN if En=1, else IDLE.
- RUN with tval≠0, no TCFG write: tval ← tval−1.
- RUN with tval=0, no TCFG write — expiry event:
  - TI set.
  - Periodic=1: tval ← load value, stay RUN.
  - Periodic=0: tval holds 0, state ← DONE.
- IDLE, DONE: tval holds. Only a TCFG write leaves these states.
- TI is set by the expiry event. It is cleared by `ticlr_we` with `ticlr_wdata[0]`=1. Otherwise it holds.
- Simultaneous set and clear in the same cycle: set wins; TI stays 1.
- Expiry and TCFG write in the same cycle: the TCFG write governs tval and state; no expiry occurs.
- TICLR with CLR=0: no effect.
- Arithmetic: unsigned; decrement never wraps because tval=0 is handled as expiry.

## Timing
- Reset values:
  - cfg = 0
  - tval = 0
  - state IDLE
  - TI = 0
  - `tcfg_rdata` = 0, `tval_rdata` = 0, `csr_timer_intr_sync` = 0
- Register updates take effect at the next clock edge. Reads reflect the post-update value from the following cycle onward.
- Write at edge k with En=1, load value L:
  - tval = L after edge k.
  - tval = 0 after edge k+L.
  - TI = 1 after edge k+L+1.
- Periodic interval between successive expiry events: L+1 cycles.
- InitVal=0, En=1, Periodic=1: expiry every cycle; TI stays set even while clears are issued.
- TICLR at edge j clears TI after edge j, provided no expiry occurs at edge j.
- Asynchronous reset mid-count: immediate return to reset values; counting resumes only after a new TCFG write.

## Structure
- Shared CSR package holds:
  - bit-position constants TCFG_EN=0, TCFG_PERIODIC=1, TCFG_INITVAL_LSB=2, TICLR_CLR=0.
  - the state encoding typedef (IDLE/RUN/DONE).
- One natural sub-module, `csr_timer_cnt`:
  - loadable CNT_W down-counter with load, enable and zero flag.
  - FSM, cfg and TI registers stay in `csr_timer`.

## Test plan
- Reset, then read:
  - Expected: both rdata ports = 0, TI = 0.
  - Write TCFG with En=0, InitVal field = 5: expected `tval_rdata` = 20, no decrement over 50 cycles, TI = 0.
- One-shot, TCFG = 0x0000_0015 (L=20, En=1, Periodic=0):
  - Expected: TI rises exactly 21 cycles after the load edge; tval holds 0.
  - No second TI after a TICLR write of 1 and 100 further cycles.
- Periodic, TCFG = 0x0000_000B (L=8):
  - Expected: expiry events 9 cycles apart.
  - Clear each TI with a TICLR write of 1: TI re-asserts every 9 cycles.
- Simultaneous TICLR=1 and expiry edge:
  - Expected: TI remains 1.
  - TICLR with data 0: TI unchanged.
- TCFG rewrite mid-count (L=40, rewrite at tval=10 with L=4):
  - Expected: tval = 4 next cycle, expiry 5 cycles later, no expiry from the old count.
- Assert `resetn` low mid-count with TI=1:
  - Expected: all outputs are 0 immediately, without waiting for a clock edge.
  - After release, the timer stays idle until the next TCFG write.

Source files
------------

// File: rtl/csr_timer_pkg.sv
// Shared CSR field positions and timer state encoding for the TCFG/TVAL/TICLR block.
// No logic; constants and types only.
// No flow control; consumers are purely combinational users of these definitions.
package csr_timer_pkg;

    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;
    localparam int TICLR_CLR        = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/csr_timer_cnt.sv
// Loadable down-counter with zero flag used as the timer value register.
// Load/decrement visible one cycle after the strobe edge; zero flag is combinational from the count.
// No backpressure; load wins over decrement, decrement is ignored at zero so the count never wraps.
module csr_timer_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    assign zero = (cnt == '0);

    // Count register: load has priority, otherwise step down until zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/csr_timer.sv
// Constant-countdown timer behind TCFG/TVAL/TICLR, source of the level timer interrupt.
// CSR writes take effect at the next edge; TI asserts one cycle after the count reaches zero.
// No backpressure: write strobes are always accepted; a TCFG write overrides a same-cycle expiry.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tcfg_we,
    input  logic [31:0] tcfg_wdata,
    input  logic        ticlr_we,
    input  logic [31:0] ticlr_wdata,
    output logic [31:0] tcfg_rdata,
    output logic [31:0] tval_rdata,
    output logic        csr_timer_intr_sync
);

    localparam int IV_W = CNT_W - TCFG_INITVAL_LSB;

    logic             cfg_en;
    logic             cfg_periodic;
    logic [IV_W-1:0]  cfg_initval;
    timer_state_t     state;
    logic             ti;

    logic [CNT_W-1:0] tval;
    logic             tval_zero;
    logic [IV_W-1:0]  wr_initval;
    logic             expire;
    logic             ti_clr;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;

    // Upper data bits beyond the implemented fields are intentionally dropped.
    logic             unused_wdata;
    assign unused_wdata = ^{tcfg_wdata, ticlr_wdata};

    assign wr_initval   = tcfg_wdata[CNT_W-1:TCFG_INITVAL_LSB];
    // Expiry only happens when no TCFG write is reloading the counter this cycle.
    assign expire       = (state == ST_RUN) && tval_zero && !tcfg_we;
    assign ti_clr       = ticlr_we && ticlr_wdata[TICLR_CLR];
    assign cnt_load     = tcfg_we || (expire && cfg_periodic);
    assign cnt_load_val = tcfg_we ? {wr_initval, 2'b00} : {cfg_initval, 2'b00};
    assign cnt_dec      = (state == ST_RUN) && !tcfg_we;

    csr_timer_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (tval),
        .zero     (tval_zero)
    );

    // Configuration fields captured on every TCFG write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_en       <= 1'b0;
            cfg_periodic <= 1'b0;
            cfg_initval  <= '0;
        end else if (tcfg_we) begin
            cfg_en       <= tcfg_wdata[TCFG_EN];
            cfg_periodic <= tcfg_wdata[TCFG_PERIODIC];
            cfg_initval  <= wr_initval;
        end
    end

    // Timer FSM: TCFG write restarts or stops; one-shot expiry parks in DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else if (tcfg_we) begin
            state <= tcfg_wdata[TCFG_EN] ? ST_RUN : ST_IDLE;
        end else if (expire && !cfg_periodic) begin
            state <= ST_DONE;
        end
    end

    // Interrupt flag: expiry sets and beats a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ti <= 1'b0;
        end else if (expire) begin
            ti <= 1'b1;
        end else if (ti_clr) begin
            ti <= 1'b0;
        end
    end

    assign tcfg_rdata          = 32'({cfg_initval, cfg_periodic, cfg_en});
    assign tval_rdata          = 32'(tval);
    assign csr_timer_intr_sync = ti;

endmodule

// File: tb/tb_csr_timer.sv
module tb_csr_timer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tcfg_we = 1'b0;
    logic [31:0] tcfg_wdata = '0;
    logic        ticlr_we = 1'b0;
    logic [31:0] ticlr_wdata = '0;
    logic [31:0] tcfg_rdata;
    logic [31:0] tval_rdata;
    logic        csr_timer_intr_sync;

    csr_timer #(.CNT_W(32)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .tcfg_we             (tcfg_we),
        .tcfg_wdata          (tcfg_wdata),
        .ticlr_we            (ticlr_we),
        .ticlr_wdata         (ticlr_wdata),
        .tcfg_rdata          (tcfg_rdata),
        .tval_rdata          (tval_rdata),
        .csr_timer_intr_sync (csr_timer_intr_sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  mask;   // bit2 tcfg, bit1 tval, bit0 ti
        logic [31:0] tcfg;
        logic [31:0] tval;
        logic        ti;
    } exp_t;

    exp_t exp_q[$];
    int   rise_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic ti_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk(input exp_t e);
        if (e.mask[2]) cmp({e.name, ".tcfg"}, tcfg_rdata, e.tcfg);
        if (e.mask[1]) cmp({e.name, ".tval"}, tval_rdata, e.tval);
        if (e.mask[0]) cmp({e.name, ".ti"}, 32'(csr_timer_intr_sync), 32'(e.ti));
    endtask

    // Monitor: drains register expectations and matches every TI rising edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) chk(exp_q.pop_front());
        if (csr_timer_intr_sync && !ti_prev) begin
            if (rise_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ti_rise: unexpected rise at cycle %0d, none expected", cyc);
            end else begin
                cmp("ti_rise_cycle", 32'(cyc), 32'(rise_q.pop_front()));
            end
        end
        ti_prev = csr_timer_intr_sync;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_all(input string n, input logic [31:0] tc, input logic [31:0] tv, input logic t);
        exp_t e;
        e.name = n; e.mask = 3'b111; e.tcfg = tc; e.tval = tv; e.ti = t;
        exp_q.push_back(e);
    endtask

    task automatic exp_tv(input string n, input logic [31:0] tv, input logic t);
        exp_t e;
        e.name = n; e.mask = 3'b011; e.tcfg = '0; e.tval = tv; e.ti = t;
        exp_q.push_back(e);
    endtask

    task automatic exp_ti(input string n, input logic t);
        exp_t e;
        e.name = n; e.mask = 3'b001; e.tcfg = '0; e.tval = '0; e.ti = t;
        exp_q.push_back(e);
    endtask

    task automatic wr_tcfg(input logic [31:0] d);
        tcfg_we = 1'b1;
        tcfg_wdata = d;
        tick();
        tcfg_we = 1'b0;
        tcfg_wdata = '0;
    endtask

    task automatic wr_ticlr(input logic [31:0] d);
        ticlr_we = 1'b1;
        ticlr_wdata = d;
        tick();
        ticlr_we = 1'b0;
        ticlr_wdata = '0;
    endtask

    initial begin
        int k;
        exp_t e;

        repeat (3) tick();
        resetn = 1'b1;
        tick();
        exp_all("reset", 32'h0, 32'h0, 1'b0);
        tick();

        // En=0, InitVal=5 -> L=20, no counting
        wr_tcfg(32'h0000_0014);
        exp_all("disabled_load", 32'h14, 32'd20, 1'b0);
        repeat (50) tick();
        exp_all("disabled_hold", 32'h14, 32'd20, 1'b0);

        // One-shot L=20
        wr_tcfg(32'h0000_0015);
        k = cyc;
        rise_q.push_back(k + 21);
        exp_tv("oneshot_load", 32'd20, 1'b0);
        repeat (10) tick();
        exp_tv("oneshot_mid", 32'd10, 1'b0);
        repeat (10) tick();
        exp_tv("oneshot_zero_no_ti", 32'd0, 1'b0);
        tick();
        exp_all("oneshot_expired", 32'h15, 32'd0, 1'b1);
        wr_ticlr(32'h1);
        exp_ti("oneshot_clr", 1'b0);
        repeat (100) tick();
        exp_tv("oneshot_done_hold", 32'd0, 1'b0);

        // Periodic L=8, cleared after each expiry
        wr_tcfg(32'h0000_000B);
        k = cyc;
        rise_q.push_back(k + 9);
        rise_q.push_back(k + 18);
        rise_q.push_back(k + 27);
        repeat (9) tick();
        for (int i = 0; i < 3; i++) begin
            exp_tv("periodic_expiry", 32'd8, 1'b1);
            wr_ticlr(32'h1);
            exp_tv("periodic_clr", 32'd7, 1'b0);
            if (i < 2) repeat (8) tick();
        end

        // Clear coincides with expiry at edge k+36: set wins
        rise_q.push_back(k + 36);
        repeat (7) tick();
        exp_tv("pre_coincide", 32'd0, 1'b0);
        wr_ticlr(32'h1);
        exp_tv("coincide_set_wins", 32'd8, 1'b1);
        wr_ticlr(32'h0);
        exp_tv("clr_zero_noeffect", 32'd7, 1'b1);
        wr_ticlr(32'h1);
        exp_tv("clr_no_expiry", 32'd6, 1'b0);

        // Rewrite mid-count: L=40 one-shot, at tval=10 rewrite with L=4
        wr_tcfg(32'h0000_0029);
        repeat (30) tick();
        exp_tv("rewrite_before", 32'd10, 1'b0);
        wr_tcfg(32'h0000_0005);
        k = cyc;
        rise_q.push_back(k + 5);
        exp_all("rewrite_load", 32'h05, 32'd4, 1'b0);
        repeat (5) tick();
        exp_tv("rewrite_expired", 32'd0, 1'b1);
        wr_ticlr(32'h1);
        exp_ti("rewrite_clr", 1'b0);
        repeat (20) tick();
        exp_tv("rewrite_no_old_expiry", 32'd0, 1'b0);

        // InitVal=0 periodic: expiry every cycle, clears cannot drop TI
        wr_tcfg(32'h0000_0003);
        k = cyc;
        rise_q.push_back(k + 1);
        tick();
        exp_all("zero_period_set", 32'h03, 32'd0, 1'b1);
        wr_ticlr(32'h1);
        exp_tv("zero_period_clr_ignored", 32'd0, 1'b1);
        wr_ticlr(32'h1);
        exp_tv("zero_period_clr_ignored2", 32'd0, 1'b1);

        // Async reset mid-count with TI=1
        wr_tcfg(32'h0000_000B);
        repeat (3) tick();
        exp_tv("pre_reset", 32'd5, 1'b1);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        e.name = "async_reset"; e.mask = 3'b111; e.tcfg = '0; e.tval = '0; e.ti = 1'b0;
        chk(e);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (30) tick();
        exp_all("post_reset_idle", 32'h0, 32'h0, 1'b0);
        tick();
        tick();

        checks++;
        if (rise_q.size() != 0) begin
            errors++;
            $display("FAIL ti_rise_missing: %0d pending rises, expected 0", rise_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
